// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, single-cycle-latency
// instruction memory interface, and a small in-order instruction queue
// toward decode. A zero instruction word marks program end and halts
// fetching until a redirect restarts it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] pc,
  output logic        fetch_complete
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Architectural state
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_addr_q, inflight_addr_d;
  logic          halted_q, halted_d;

  // Queue storage
  logic [31:0] q_instr [QDEPTH];
  logic [31:0] q_pc    [QDEPTH];

  // Derived control
  logic          pop;
  logic          push;
  logic          end_marker;
  logic [CW:0]   occupancy;
  logic          room;

  // Word alignment drops the low redirect bits on purpose.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid & dec_ready;

  // A returning zero word halts fetch in the same cycle it arrives, so no
  // request is issued past the end marker.
  assign end_marker = inflight_q & (imem_rdata == 32'h0000_0000);
  assign push       = inflight_q & ~redirect_valid & ~end_marker;

  // Slots already committed (queued plus in flight) after this cycle's pop;
  // a new request is only issued when it is guaranteed a queue slot.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign room      = (occupancy < (CW+1)'(QDEPTH));

  assign imem_req  = reset & ~halted_q & ~end_marker & ~redirect_valid & room;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  assign dec_instr = dec_valid ? q_instr[head_q] : 32'h0000_0000;
  assign dec_pc    = dec_valid ? q_pc[head_q]    : 32'h0000_0000;

  assign fetch_complete = halted_q & (count_q == '0) & ~inflight_q;

  // Next-state computation for PC, queue pointers, in-flight and halt flags
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    pc_d            = pc_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    halted_d        = halted_q;
    inflight_d      = imem_req;
    inflight_addr_d = imem_req ? pc_q : inflight_addr_q;

    if (redirect_valid) begin
      // Redirect overrides any push, pop or pending response this cycle.
      pc_d     = {redirect_pc[31:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (imem_req)   pc_d     = pc_q + 32'd4;
      if (end_marker) halted_d = 1'b1;
      if (push)       tail_d   = tail_q + PW'(1);
      if (pop)        head_d   = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      pc_q            <= RESET_PC;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= 32'h0000_0000;
      halted_q        <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      halted_q        <= halted_d;
    end
  end

  // Queue payload write at the tail
  // NOTE: the storage array has no reset; stale entries are never visible
  // because outputs are masked by dec_valid and pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail_q] <= imem_rdata;
      q_pc[tail_q]    <= inflight_addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors covers
// reset release, streaming to an end marker and backpressure; hand-written
// sequences cover redirects, restart after halt and async reset.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req, redirect_valid, dec_valid, dec_ready, fetch_complete;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc, pc;

  logic        w_imem_req, w_dec_valid, w_fetch_complete;
  logic [31:0] w_imem_addr, w_imem_rdata, w_dec_instr, w_dec_pc, w_pc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [64];
  logic [31:0] rd_addr_q;
  logic [31:0] w_rd_addr_q;

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .pc(pc), .fetch_complete(fetch_complete)
  );

  // Second instance exercising the PC wrap from the top of the address space
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(4)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .dec_valid(w_dec_valid), .dec_ready(1'b1),
    .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
    .pc(w_pc), .fetch_complete(w_fetch_complete)
  );

  // Instruction memory models: data valid one cycle after the address
  always @(posedge clk) begin
    rd_addr_q   <= imem_addr;
    w_rd_addr_q <= w_imem_addr;
  end
  assign imem_rdata   = mem[rd_addr_q[7:2]];
  assign w_imem_rdata = {w_rd_addr_q[31:2], 2'b11};

  function automatic logic [31:0] prog_word(input logic [31:0] a);
    return 32'h0000_0013 | (a << 12);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        dec_ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_dv;
    logic [31:0] e_dpc;
    logic [31:0] e_instr;
    logic        e_fc;
    logic        w_chk;
    logic [31:0] w_dpc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic req, input logic [31:0] epc, input logic dv,
                     input logic [31:0] dpc, input logic [31:0] ins, input logic fc,
                     input logic wchk = 1'b0, input logic [31:0] wdpc = 32'h0);
    vec_t v;
    v.dec_ready = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = req; v.e_pc = epc; v.e_dv = dv; v.e_dpc = dpc;
    v.e_instr = ins; v.e_fc = fc; v.w_chk = wchk; v.w_dpc = wdpc;
    vecs.push_back(v);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      dec_ready      = vecs[i].dec_ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("v%0d.imem_req", i),   {31'b0, imem_req},       {31'b0, vecs[i].e_req});
      check($sformatf("v%0d.pc", i),         pc,                      vecs[i].e_pc);
      check($sformatf("v%0d.imem_addr", i),  imem_addr,               vecs[i].e_pc);
      check($sformatf("v%0d.dec_valid", i),  {31'b0, dec_valid},      {31'b0, vecs[i].e_dv});
      check($sformatf("v%0d.dec_pc", i),     dec_pc,                  vecs[i].e_dpc);
      check($sformatf("v%0d.dec_instr", i),  dec_instr,               vecs[i].e_instr);
      check($sformatf("v%0d.fetch_cmpl", i), {31'b0, fetch_complete}, {31'b0, vecs[i].e_fc});
      if (vecs[i].w_chk)
        check($sformatf("v%0d.wrap_dec_pc", i), w_dec_pc, vecs[i].w_dpc);
      advance();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_stream;
    int n_bp;

    reset          = 1'b0;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = prog_word(32'(i * 4));
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.imem_req",  {31'b0, imem_req},       32'h0);
    check("rst.pc",        pc,                      32'h0);
    check("rst.dec_valid", {31'b0, dec_valid},      32'h0);
    check("rst.dec_pc",    dec_pc,                  32'h0);
    check("rst.dec_instr", dec_instr,               32'h0);
    check("rst.fc",        {31'b0, fetch_complete}, 32'h0);
    check("rst.wrap_pc",   w_pc,                    32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Streaming to an end marker at 0x08, wrap instance checked alongside
    add(1, 0, 0, 1, 32'h0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h4, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h8, 1, 32'h0, 32'h0050_0093, 0, 1, 32'hFFFF_FFFC);
    add(1, 0, 0, 0, 32'hC, 1, 32'h4, 32'h0010_0113, 0, 1, 32'h0000_0000);
    add(1, 0, 0, 0, 32'hC, 0, 0, 0, 1);
    add(1, 0, 0, 0, 32'hC, 0, 0, 0, 1);
    n_stream = vecs.size();

    // Backpressure: redirect to 0 from halt, decode stalled for 10 cycles
    add(0, 1, 32'h0, 0, 32'hC, 0, 0, 0, 1);
    add(0, 0, 0, 1, 32'h0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h4, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h8, 1, 32'h0, prog_word(32'h0), 0);
    add(0, 0, 0, 1, 32'hC, 1, 32'h0, prog_word(32'h0), 0);
    for (int k = 4; k < 10; k++) add(0, 0, 0, 0, 32'h10, 1, 32'h0, prog_word(32'h0), 0);
    add(1, 0, 0, 1, 32'h10, 1, 32'h0, prog_word(32'h0), 0);
    add(1, 0, 0, 1, 32'h14, 1, 32'h4, prog_word(32'h4), 0);
    add(1, 0, 0, 1, 32'h18, 1, 32'h8, prog_word(32'h8), 0);
    add(1, 0, 0, 1, 32'h1C, 1, 32'hC, prog_word(32'hC), 0);
    add(1, 0, 0, 1, 32'h20, 1, 32'h10, prog_word(32'h10), 0);
    n_bp = vecs.size();

    run_vecs(0, n_stream - 1);
    mem[0] = prog_word(32'h0);
    mem[1] = prog_word(32'h4);
    mem[2] = prog_word(32'h8);
    run_vecs(n_stream, n_bp - 1);

    // Redirect with three queued entries and one response in flight
    mem[24] = 32'h0000_0000;
    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    advance();
    repeat (4) advance();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    check("redir.pre_dv",  {31'b0, dec_valid}, 32'h1);
    check("redir.pre_req", {31'b0, imem_req},  32'h0);
    advance();
    @(negedge clk);
    check("redir.dv",  {31'b0, dec_valid}, 32'h0);
    check("redir.pc",  pc,                 32'h40);
    check("redir.req", {31'b0, imem_req},  32'h1);
    advance();
    dec_ready = 1'b1;
    @(negedge clk);
    check("redir.pc2", pc,                 32'h44);
    check("redir.dv2", {31'b0, dec_valid}, 32'h0);
    advance();
    @(negedge clk);
    check("redir.first_pc",    dec_pc,    32'h40);
    check("redir.first_instr", dec_instr, prog_word(32'h40));
    advance();
    @(negedge clk);
    check("redir.second_pc", dec_pc, 32'h44);
    advance();

    // Run into the end marker at 0x60, then restart with a redirect
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fetch_complete) break;
    end
    check("halt.fc",  {31'b0, fetch_complete}, 32'h1);
    check("halt.pc",  pc,                      32'h64);
    check("halt.req", {31'b0, imem_req},       32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    advance();
    @(negedge clk);
    check("restart.fc",   {31'b0, fetch_complete}, 32'h0);
    check("restart.pc",   pc,                      32'h100);
    check("restart.req",  {31'b0, imem_req},       32'h1);
    check("restart.addr", imem_addr,               32'h100);
    advance();
    advance();
    @(negedge clk);
    check("restart.dec_pc", dec_pc, 32'h100);
    advance();

    // Async reset between edges with a full queue
    mem[24] = prog_word(32'h60);
    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    advance();
    repeat (6) advance();
    @(negedge clk);
    check("areset.pre_dv",  {31'b0, dec_valid}, 32'h1);
    check("areset.pre_req", {31'b0, imem_req},  32'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("areset.dv",        {31'b0, dec_valid},      32'h0);
    check("areset.pc",        pc,                      32'h0);
    check("areset.req",       {31'b0, imem_req},       32'h0);
    check("areset.dec_pc",    dec_pc,                  32'h0);
    check("areset.dec_instr", dec_instr,               32'h0);
    check("areset.fc",        {31'b0, fetch_complete}, 32'h0);
    check("areset.wrap_pc",   w_pc,                    32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("release.req",  {31'b0, imem_req}, 32'h1);
    check("release.addr", imem_addr,         32'h0);
    advance();
    @(negedge clk);
    check("release.pc", pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
